// File: rtl/ram_pkg.sv
// ram_pkg: shared widths, RAM depth and master FSM state encoding
// for the 16x8 tri-state RAM bus.
package ram_pkg;

  localparam int RAM_DEPTH  = 16;
  localparam int ADDR_W_DEF = $clog2(RAM_DEPTH);
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_TURN = 3'd3,
    ST_VFY  = 3'd4,
    ST_CHK  = 3'd5
  } ram_state_t;

endpackage

// File: rtl/ram_bus_drv.sv
// ram_bus_drv: registered tri-state pad. Drive enable and drive data are
// flops so the bus switches only on clk edges; the bus is also sampled out.
module ram_bus_drv #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drive,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] sample,
  inout  wire  [DATA_W-1:0] bus
);

  logic              en;
  logic [DATA_W-1:0] dq;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en <= 1'b0;
      dq <= '0;
    end else begin
      en <= drive;
      if (drive) dq <= wdata;
    end
  end

  assign bus    = en ? dq : 'z;
  assign sample = bus;

endmodule

// File: rtl/ram_master.sv
// ram_master: accepts one read/write command at a time and sequences
// cs/oa/wa/addr onto the RAM. Define RAM_MASTER_WRITE_VERIFY_EN to add a
// read-back after every write with a sticky err output.
module ram_master
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              cs,
  output logic              oa,
  output logic              wa,
`ifdef RAM_MASTER_WRITE_VERIFY_EN
  output logic              err,
`endif
  inout  wire  [DATA_W-1:0] bus
);

  ram_state_t        state;
  logic              accept;
  logic [DATA_W-1:0] bus_in;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
  logic [DATA_W-1:0] wdata_q;
`endif

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // The pad drives for exactly the WR cycle: its enable loads on the accept
  // edge of a write and clears on the edge that leaves WR.
  ram_bus_drv #(.DATA_W(DATA_W)) u_pad (
    .clk    (clk),
    .rst    (rst),
    .drive  (accept && req_we),
    .wdata  (req_wdata),
    .sample (bus_in),
    .bus    (bus)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cs        <= 1'b0;
      oa        <= 1'b0;
      wa        <= 1'b0;
      addr      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
      wdata_q   <= '0;
      err       <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr  <= req_addr;
            cs    <= 1'b1;
            wa    <= req_we;
            oa    <= !req_we;
            state <= req_we ? ST_WR : ST_RD;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
            wdata_q <= req_wdata;
`endif
          end
        end
        ST_WR: begin
          wa <= 1'b0;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
          // Pad releases on this same edge, so oa rising never meets a drive.
          oa    <= 1'b1;
          state <= ST_VFY;
`else
          cs    <= 1'b0;
          state <= ST_IDLE;
`endif
        end
        ST_RD: begin
          rsp_rdata <= bus_in;
          rsp_valid <= 1'b1;
          cs        <= 1'b0;
          oa        <= 1'b0;
          state     <= ST_TURN;
        end
`ifdef RAM_MASTER_WRITE_VERIFY_EN
        ST_VFY: begin
          if (bus_in != wdata_q) err <= 1'b1;
          cs    <= 1'b0;
          oa    <= 1'b0;
          state <= ST_CHK;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: drives random read/write commands into ram_master with a
// behavioural 16x8 RAM on the bus and a reference memory for expected data.
module tb_ram_master;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] addr;
  logic          cs, oa, wa;
  wire  [DW-1:0] bus;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
  logic          err;
  bit            exp_err = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_rdata = '0;
  bit            corrupt = 1'b0;

  always #5 clk = ~clk;

  ram_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .addr      (addr),
    .cs        (cs),
    .oa        (oa),
    .wa        (wa),
`ifdef RAM_MASTER_WRITE_VERIFY_EN
    .err       (err),
`endif
    .bus       (bus)
  );

  wire drv_en = dut.u_pad.en;

  // RAM responder; 'corrupt' makes word 2 read back as 0x80.
  assign bus = (cs && oa) ? ((corrupt && addr == 4'd2) ? 8'h80 : ram_mem[addr]) : 'z;
  always @(posedge clk) if (cs && wa) ram_mem[addr] <= bus;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && oa) begin
      check("no_drive_while_oa", 32'(drv_en), 0);
      check("no_x_on_bus", 32'($isunknown(bus)), 0);
    end
  end

  // Presents a command, waits for the accepting edge, then scrambles req_*.
  task automatic accept(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int budget = 16;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("ready_wait", 32'(budget > 0), 1);
    @(posedge clk);
    if (we) ref_mem[a] = d;
    #1;
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    req_we    = 1'($urandom);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    accept(1'b1, a, d);
    @(negedge clk);
    check("wr_cs", 32'(cs), 1);
    check("wr_wa", 32'(wa), 1);
    check("wr_oa", 32'(oa), 0);
    check("wr_addr", 32'(addr), 32'(a));
    check("wr_bus", 32'(bus), 32'(d));
    check("wr_ready", 32'(req_ready), 0);
    check("wr_rsp_valid", 32'(rsp_valid), 0);
`ifdef RAM_MASTER_WRITE_VERIFY_EN
    @(negedge clk);
    check("vfy_cs", 32'(cs), 1);
    check("vfy_oa", 32'(oa), 1);
    check("vfy_wa", 32'(wa), 0);
    check("vfy_addr", 32'(addr), 32'(a));
    check("vfy_ready", 32'(req_ready), 0);
    if (corrupt && a == 4'd2 && d != 8'h80) exp_err = 1'b1;
    @(negedge clk);
    check("chk_cs", 32'(cs), 0);
    check("chk_ready", 32'(req_ready), 0);
    check("chk_err", 32'(err), 32'(exp_err));
    check("chk_rsp_valid", 32'(rsp_valid), 0);
`endif
    @(negedge clk);
    req_valid = 1'b0;
    check("wr_done_cs", 32'(cs), 0);
    check("wr_done_wa", 32'(wa), 0);
    check("wr_done_drive", 32'(drv_en), 0);
    check("wr_done_ready", 32'(req_ready), 1);
    check("wr_done_rsp_valid", 32'(rsp_valid), 0);
    check("wr_hold_rdata", 32'(rsp_rdata), 32'(exp_rdata));
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    accept(1'b0, a, '0);
    @(negedge clk);
    check("rd_cs", 32'(cs), 1);
    check("rd_oa", 32'(oa), 1);
    check("rd_wa", 32'(wa), 0);
    check("rd_addr", 32'(addr), 32'(a));
    check("rd_ready", 32'(req_ready), 0);
    check("rd_rsp_early", 32'(rsp_valid), 0);
    exp_rdata = ref_mem[a];
    @(negedge clk);
    check("turn_rsp_valid", 32'(rsp_valid), 1);
    check("turn_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    check("turn_cs", 32'(cs), 0);
    check("turn_ready", 32'(req_ready), 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("rd_done_rsp_valid", 32'(rsp_valid), 0);
    check("rd_done_ready", 32'(req_ready), 1);
    check("rd_hold_rdata", 32'(rsp_rdata), 32'(exp_rdata));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_cs", 32'(cs), 0);
    check("rst_oa", 32'(oa), 0);
    check("rst_wa", 32'(wa), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_drive", 32'(drv_en), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 1);

    do_write(4'd3, 8'hA5);
    do_read(4'd3);

    for (int a = 0; a < 16; a++) do_write(AW'(a), DW'(a) ^ 8'h5A);
    for (int a = 0; a < 16; a++) do_read(AW'(a));

    // Read then write the same word back-to-back with req_valid held high.
    do_read(4'd7);
    do_write(4'd7, 8'h3C);
    do_read(4'd7);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) do_write(AW'($urandom), DW'($urandom));
      else do_read(AW'($urandom));
    end

    // Reset in the middle of a read: controls drop before the next edge.
    accept(1'b0, 4'd5, '0);
    @(negedge clk);
    #1 rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check("mid_rst_cs", 32'(cs), 0);
    check("mid_rst_oa", 32'(oa), 0);
    check("mid_rst_wa", 32'(wa), 0);
    check("mid_rst_drive", 32'(drv_en), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    exp_rdata = '0;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
    exp_err = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready", 32'(req_ready), 1);
    check("post_rst_rdata", 32'(rsp_rdata), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 0);
      check("post_rst_cs", 32'(cs), 0);
    end
    do_read(4'hF);

`ifdef RAM_MASTER_WRITE_VERIFY_EN
    do_write(4'd2, 8'h81);
    check("vfy_clean_err", 32'(err), 0);
    corrupt = 1'b1;
    do_write(4'd2, 8'h81);
    do_write(4'd9, 8'h44);
    repeat (4) @(negedge clk);
    check("vfy_err_sticky", 32'(err), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    corrupt = 1'b0;
    exp_err = 1'b0;
    check("vfy_err_cleared", 32'(err), 0);
    do_write(4'd2, 8'h81);
    check("vfy_good_err", 32'(err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
